// File: rtl/keypad_scan_debounce.sv
// Row-scanning 4x4 active-low keypad reader. Columns are synchronised, sampled once
// per row dwell, reduced to one prioritised key per frame, and debounced frame by frame.
module keypad_scan_debounce #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keyCol,
   output logic [3:0] keyRow,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DwW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [DwW-1:0]  DwLast = DwW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StPressChk = 2'd1;
   localparam logic [1:0] StHeld     = 2'd2;
   localparam logic [1:0] StRelChk   = 2'd3;

   logic [3:0]      col_meta_q, col_meta_d;
   logic [3:0]      col_sync_q, col_sync_d;
   logic [DwW-1:0]  dwell_q, dwell_d;
   logic [1:0]      row_q, row_d;
   logic            acc_found_q, acc_found_d;
   logic [3:0]      acc_code_q, acc_code_d;
   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      cand_q, cand_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;

   logic            dwell_end;
   logic            frame_end;
   logic [3:0]      col_low;
   logic            col_any;
   logic [1:0]      col_idx;
   logic            frm_found;
   logic [3:0]      frm_code;
   logic [CntW-1:0] cnt_inc;

   // Two-flop synchroniser on the asynchronous column returns.
   always_comb begin
      col_meta_d = keyCol;
      col_sync_d = col_meta_q;
   end

   // Row dwell counter and row rotation; the last dwell cycle is the sample point.
   always_comb begin
      dwell_end = (dwell_q == DwLast);
      frame_end = dwell_end && (row_q == 2'd3);
      dwell_d   = dwell_end ? '0 : dwell_q + 1'b1;
      row_d     = dwell_end ? row_q + 2'd1 : row_q;
   end

   // Row drive decode: exactly one row pulled low.
   always_comb begin
      case (row_q)
         2'd0:    keyRow = 4'b1110;
         2'd1:    keyRow = 4'b1101;
         2'd2:    keyRow = 4'b1011;
         default: keyRow = 4'b0111;
      endcase
   end

   // Lowest-numbered low column wins within a row.
   always_comb begin
      col_low = ~col_sync_q;
      col_any = |col_low;
      col_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (col_low[i]) col_idx = 2'(i);
      end
   end

   // Frame accumulator keeps the first key found; rows are visited in ascending order,
   // so the first hit is already the lowest row.
   always_comb begin
      acc_found_d = acc_found_q;
      acc_code_d  = acc_code_q;
      frm_found   = acc_found_q | col_any;
      frm_code    = acc_found_q ? acc_code_q : {row_q, col_idx};
      if (dwell_end) begin
         if (frame_end) begin
            acc_found_d = 1'b0;
            acc_code_d  = 4'd0;
         end else if (!acc_found_q && col_any) begin
            acc_found_d = 1'b1;
            acc_code_d  = {row_q, col_idx};
         end
      end
   end

   // Debounce FSM, advanced only at frame end.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      if (frame_end) begin
         case (state_q)
            StIdle: begin
               if (frm_found) begin
                  cand_d = frm_code;
                  if (DEBOUNCE_CNT <= 1) begin
                     state_d     = StHeld;
                     key_code_d  = frm_code;
                     key_valid_d = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     state_d = StPressChk;
                     cnt_d   = CntOne;
                  end
               end
            end
            StPressChk: begin
               if (!frm_found) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (frm_code == cand_q) begin
                  if (cnt_inc == CntMax) begin
                     state_d     = StHeld;
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cand_d = frm_code;
                  cnt_d  = CntOne;
               end
            end
            StHeld: begin
               if (!frm_found) begin
                  if (DEBOUNCE_CNT <= 1) begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     state_d = StRelChk;
                     cnt_d   = CntOne;
                  end
               end
            end
            default: begin
               // Any key during release checking cancels the release silently.
               if (frm_found) begin
                  state_d = StHeld;
                  cnt_d   = '0;
               end else if (cnt_inc == CntMax) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         endcase
      end
   end

   // Output drive.
   always_comb begin
      key_code  = key_code_q;
      key_valid = key_valid_q;
      key_held  = (state_q == StHeld) || (state_q == StRelChk);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_meta_q  <= 4'hF;
         col_sync_q  <= 4'hF;
         dwell_q     <= '0;
         row_q       <= 2'd0;
         acc_found_q <= 1'b0;
         acc_code_q  <= 4'd0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         cand_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
      end else begin
         col_meta_q  <= col_meta_d;
         col_sync_q  <= col_sync_d;
         dwell_q     <= dwell_d;
         row_q       <= row_d;
         acc_found_q <= acc_found_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

endmodule
